// File: rtl/ram_ctrl_pkg.sv
// Shared parameters and FSM state type for the 32x3 RAM front-end controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_ctrl_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 3;
   localparam int DEPTH  = 32;
   localparam logic [DATA_W-1:0] CLEAR_VAL = '0;

   typedef enum logic {S_CLEAR, S_RUN} ctrl_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; port 0 is favoured after reset.
// Latency: grant is combinational from req/en; last-grant history updates on the clock edge.
// Backpressure: a requester simply holds req until it sees its gnt bit; en=0 withholds all grants.
module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // last_gnt=1 means port 1 won most recently, so port 0 wins the next tie.
   logic last_gnt;

   // Grant the sole requester; on a tie, grant the port that did not win last.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0] && (!req[1] || last_gnt)) begin
            gnt[0] = 1'b1;
         end else if (req[1]) begin
            gnt[1] = 1'b1;
         end
      end
   end

   // Remember the winner of every grant so ties alternate.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_gnt <= 1'b1;
      end else if (gnt != 2'b00) begin
         last_gnt <= gnt[1];
      end
   end

endmodule

// File: rtl/ram32x3_arbiter.sv
// Front-end for a 32x3 single-port RAM: clears every word after reset, then shares it round-robin between two ports.
// Latency: grant and RAM access in the request cycle; read data valid one cycle after a granted read.
// Backpressure: a request is held until its combinational gnt; no grants while reset is high or clearing.
module ram32x3_arbiter #(
   parameter int                ADDR_W    = ram_ctrl_pkg::ADDR_W,
   parameter int                DATA_W    = ram_ctrl_pkg::DATA_W,
   parameter int                DEPTH     = ram_ctrl_pkg::DEPTH,
   parameter logic [DATA_W-1:0] CLEAR_VAL = ram_ctrl_pkg::CLEAR_VAL
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_enable,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_datain,
   input  logic [DATA_W-1:0] ram_dataout
);

   import ram_ctrl_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   ctrl_state_t       state;
   ctrl_state_t       state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic              rvalid0_q;
   logic              rvalid1_q;
   logic              arb_en;
   logic [1:0]        arb_gnt;

   // Arbitration only runs once the clear has finished and never in a reset cycle.
   assign arb_en = (state == S_RUN) && !reset;

   rr_arbiter2 u_arb (
      .clock (clock),
      .reset (reset),
      .en    (arb_en),
      .req   ({req1, req0}),
      .gnt   (arb_gnt)
   );

   assign gnt0 = arb_gnt[0];
   assign gnt1 = arb_gnt[1];

   // State register: reset always restarts the clear walk.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Clear address walks 0..DEPTH-1, then parks at 0 for the next clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         clr_cnt <= '0;
      end else if (state == S_CLEAR) begin
         if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
         end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
         end
      end
   end

   // Next state plus RAM port mux: clear writes while clearing, the granted port's access while running.
   always_comb begin
      state_nxt   = state;
      ready       = 1'b0;
      ram_enable  = 1'b0;
      ram_wren    = 1'b0;
      ram_address = '0;
      ram_datain  = '0;
      if (!reset) begin
         case (state)
            S_CLEAR: begin
               ram_enable  = 1'b1;
               ram_wren    = 1'b1;
               ram_address = clr_cnt;
               ram_datain  = CLEAR_VAL;
               if (clr_cnt == LAST_ADDR) begin
                  state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               ready = 1'b1;
               if (arb_gnt[0]) begin
                  ram_enable  = 1'b1;
                  ram_wren    = wr0;
                  ram_address = addr0;
                  ram_datain  = wdata0;
               end else if (arb_gnt[1]) begin
                  ram_enable  = 1'b1;
                  ram_wren    = wr1;
                  ram_address = addr1;
                  ram_datain  = wdata1;
               end
            end
            default: begin
               state_nxt = S_CLEAR;
            end
         endcase
      end
   end

   // Read-valid strobes track the RAM's one-cycle registered read.
   always_ff @(posedge clock) begin
      if (reset) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= gnt0 && !wr0;
         rvalid1_q <= gnt1 && !wr1;
      end
   end

   // A read still in flight when reset arrives is dropped rather than reported.
   assign rvalid0 = rvalid0_q && !reset;
   assign rvalid1 = rvalid1_q && !reset;

   // RAM output is shared; the rvalid strobes say whose data it is.
   assign rdata0 = ram_dataout;
   assign rdata1 = ram_dataout;

endmodule

// File: tb/tb_ram32x3_arbiter.sv
// Bench for ram32x3_arbiter with a behavioural 32x3 single-port RAM behind it.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram32x3_arbiter;

   typedef struct {
      logic [2:0] d;
      int         cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       req0, req1, wr0, wr1;
   logic [4:0] addr0, addr1;
   logic [2:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, ready;
   logic [2:0] rdata0, rdata1;
   logic [4:0] ram_address;
   logic       ram_enable, ram_wren;
   logic [2:0] ram_datain;
   logic [2:0] ram_dataout = 3'b000;

   logic [2:0] mem [0:31];
   logic       mem_init = 1'b0;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t m0;
   exp_t m1;

   always #5 clock = ~clock;

   ram32x3_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req0        (req0),
      .req1        (req1),
      .wr0         (wr0),
      .wr1         (wr1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .rvalid0     (rvalid0),
      .rvalid1     (rvalid1),
      .rdata0      (rdata0),
      .rdata1      (rdata1),
      .ready       (ready),
      .ram_address (ram_address),
      .ram_enable  (ram_enable),
      .ram_wren    (ram_wren),
      .ram_datain  (ram_datain),
      .ram_dataout (ram_dataout)
   );

   // Behavioural RAM: starts full of 3'b111 so the clear is observable.
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 3'b111;
         mem_init <= 1'b1;
      end else if (ram_enable) begin
         if (ram_wren) mem[ram_address] <= ram_datain;
         ram_dataout <= mem[ram_address];
      end
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected read data shows up at the negedge after the next posedge.
   task automatic push(input bit p, input logic [2:0] e);
      exp_t x;
      x.d   = e;
      x.cyc = cyc + 1;
      if (p) q1.push_back(x);
      else   q0.push_back(x);
   endtask

   // Single-port access that must be granted in its first cycle.
   task automatic access(input bit p, input bit w, input logic [4:0] a,
                         input logic [2:0] d, input logic [2:0] e);
      if (!p) begin
         req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
      end
      @(negedge clock);
      chk(p ? "gnt1 solo" : "gnt0 solo", p ? gnt1 : gnt0, 1);
      chk(p ? "gnt0 idle" : "gnt1 idle", p ? gnt0 : gnt1, 0);
      if (!w) push(p, e);
      @(posedge clock); #1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   // Checks the full clear walk; optionally raises a port-0 read of addr 5 at clear cycle 10.
   task automatic clear_phase(input bit with_req);
      for (int i = 0; i < 32; i++) begin
         if (with_req && i == 10) begin
            req0 = 1'b1; wr0 = 1'b0; addr0 = 5'd5;
         end
         @(negedge clock);
         chk("clr enable", ram_enable, 1);
         chk("clr wren", ram_wren, 1);
         chk("clr addr", ram_address, i);
         chk("clr data", ram_datain, 0);
         chk("clr ready", ready, 0);
         chk("clr gnt0", gnt0, 0);
         chk("clr gnt1", gnt1, 0);
         @(posedge clock); #1;
      end
      @(negedge clock);
      chk("ready after clear", ready, 1);
      if (with_req) begin
         chk("first run gnt0", gnt0, 1);
         push(1'b0, 3'b000);
      end else begin
         chk("idle enable", ram_enable, 0);
      end
      @(posedge clock); #1;
      req0 = 1'b0;
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expectation, data and cycle.
   always @(negedge clock) begin
      chk("gnt exclusive", gnt0 & gnt1, 0);
      if (rvalid0) begin
         if (q0.size() == 0) begin
            chk("rvalid0 spurious", rvalid0, 0);
         end else begin
            m0 = q0.pop_front();
            chk("rdata0", rdata0, m0.d);
            chk("rvalid0 cycle", cyc, m0.cyc);
         end
      end
      if (rvalid1) begin
         if (q1.size() == 0) begin
            chk("rvalid1 spurious", rvalid1, 0);
         end else begin
            m1 = q1.pop_front();
            chk("rdata1", rdata1, m1.d);
            chk("rvalid1 cycle", cyc, m1.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset state: everything quiet even with requests pending.
      @(negedge clock);
      chk("rst ready", ready, 0);
      chk("rst gnt0", gnt0, 0);
      chk("rst gnt1", gnt1, 0);
      chk("rst enable", ram_enable, 0);
      chk("rst wren", ram_wren, 0);
      chk("rst rvalid0", rvalid0, 0);
      chk("rst rvalid1", rvalid1, 0);
      @(posedge clock); #1;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;

      // 1: clear walk, then edge words read back 0.
      clear_phase(1'b0);
      access(1'b0, 1'b0, 5'd0, 3'b000, 3'b000);
      access(1'b1, 1'b0, 5'd31, 3'b000, 3'b000);

      // 2: write on port 0, read it back on port 1 the next cycle.
      access(1'b0, 1'b1, 5'd7, 3'b101, 3'b000);
      access(1'b1, 1'b0, 5'd7, 3'b000, 3'b101);
      access(1'b1, 1'b1, 5'd20, 3'b011, 3'b000);

      // 3: both ports read continuously; port 1 won last, so 0,1,0,1.
      req0 = 1'b1; wr0 = 1'b0; addr0 = 5'd7;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 5'd20;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("rr gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
         chk("rr gnt1", gnt1, (k % 2 == 1) ? 1 : 0);
         if (k % 2 == 0) push(1'b0, 3'b101);
         else            push(1'b1, 3'b011);
         @(posedge clock); #1;
      end
      req0 = 1'b0; req1 = 1'b0;

      // 4: back-to-back writes, then port 1 streams three reads.
      access(1'b0, 1'b1, 5'd1, 3'b001, 3'b000);
      access(1'b0, 1'b1, 5'd2, 3'b010, 3'b000);
      access(1'b0, 1'b1, 5'd3, 3'b100, 3'b000);
      access(1'b1, 1'b0, 5'd1, 3'b000, 3'b001);
      access(1'b1, 1'b0, 5'd2, 3'b000, 3'b010);
      access(1'b1, 1'b0, 5'd3, 3'b000, 3'b100);

      // 6: addr 5 holds 110; reset lands the cycle after its read is granted.
      access(1'b0, 1'b1, 5'd5, 3'b110, 3'b000);
      req0 = 1'b1; wr0 = 1'b0; addr0 = 5'd5;
      @(negedge clock);
      chk("pre-reset gnt0", gnt0, 1);
      @(posedge clock); #1;
      req0 = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      chk("midrst rvalid0", rvalid0, 0);
      chk("midrst ready", ready, 0);
      chk("midrst gnt0", gnt0, 0);
      chk("midrst enable", ram_enable, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // 5: req0 raised mid-clear is held off, then wins the first run cycle; addr 5 now reads 0.
      clear_phase(1'b1);
      access(1'b1, 1'b0, 5'd7, 3'b000, 3'b000);

      repeat (3) @(posedge clock);
      #1;
      chk("q0 drained", q0.size(), 0);
      chk("q1 drained", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
